// File: rtl/bypass_rf_fetch_client_if.sv
// Signal bundle between the fetch client, decode, the bypass register file and execute.
// The master side is the fetch client; the slave side is everything around it.
interface bypass_rf_fetch_client_if #(
    parameter int addr_width = 1,
    parameter int data_width = 1,
    parameter int name_width = 1,
    parameter int cnt_width  = 16
);
    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic [addr_width-1:0] REQ_RS1;
    logic [addr_width-1:0] REQ_RS2;
    logic [addr_width-1:0] REQ_RD;
    logic                  REQ_HAS_RD;

    logic [addr_width-1:0] ADDR_IN;
    logic                  ALLOC_E;
    logic                  ALLOC_READY;
    logic [name_width-1:0] NAME_OUT;

    logic [addr_width-1:0] ADDR_1;
    logic [addr_width-1:0] ADDR_2;
    logic                  RRESE_1;
    logic                  RRESE_2;
    logic                  RRES_READY_1;
    logic                  RRES_READY_2;
    logic [name_width-1:0] RNAME_OUT_1;
    logic [name_width-1:0] RNAME_OUT_2;

    logic [name_width-1:0] VALID_NAME_1;
    logic [name_width-1:0] VALID_NAME_2;
    logic                  VALID_OUT_1;
    logic                  VALID_OUT_2;
    logic [name_width-1:0] NAME_1;
    logic [name_width-1:0] NAME_2;
    logic [data_width-1:0] D_OUT_1;
    logic [data_width-1:0] D_OUT_2;

    logic [name_width-1:0] RD_F_1;
    logic [name_width-1:0] RD_F_2;
    logic                  FE_1;
    logic                  FE_2;

    logic                  RESP_VALID;
    logic                  RESP_READY;
    logic [data_width-1:0] RESP_D1;
    logic [data_width-1:0] RESP_D2;
    logic [name_width-1:0] RESP_WNAME;
    logic                  RESP_HAS_WN;
    logic [cnt_width-1:0]  STALL_CNT;

    modport master (
        input  REQ_VALID, REQ_RS1, REQ_RS2, REQ_RD, REQ_HAS_RD,
        output REQ_READY,
        output ADDR_IN, ALLOC_E,
        input  ALLOC_READY, NAME_OUT,
        output ADDR_1, ADDR_2, RRESE_1, RRESE_2,
        input  RRES_READY_1, RRES_READY_2, RNAME_OUT_1, RNAME_OUT_2,
        output VALID_NAME_1, VALID_NAME_2, NAME_1, NAME_2,
        input  VALID_OUT_1, VALID_OUT_2, D_OUT_1, D_OUT_2,
        output RD_F_1, RD_F_2, FE_1, FE_2,
        output RESP_VALID, RESP_D1, RESP_D2, RESP_WNAME, RESP_HAS_WN, STALL_CNT,
        input  RESP_READY
    );

    modport slave (
        output REQ_VALID, REQ_RS1, REQ_RS2, REQ_RD, REQ_HAS_RD,
        input  REQ_READY,
        input  ADDR_IN, ALLOC_E,
        output ALLOC_READY, NAME_OUT,
        input  ADDR_1, ADDR_2, RRESE_1, RRESE_2,
        output RRES_READY_1, RRES_READY_2, RNAME_OUT_1, RNAME_OUT_2,
        input  VALID_NAME_1, VALID_NAME_2, NAME_1, NAME_2,
        output VALID_OUT_1, VALID_OUT_2, D_OUT_1, D_OUT_2,
        input  RD_F_1, RD_F_2, FE_1, FE_2,
        input  RESP_VALID, RESP_D1, RESP_D2, RESP_WNAME, RESP_HAS_WN, STALL_CNT,
        output RESP_READY
    );
endinterface

// File: rtl/bypass_rf_fetch_client.sv
// Requester side of the bypass register-file lock protocol: reserves a write name and
// both read slots atomically, gathers forwarded operands, frees the slots, hands off to execute.
module bypass_rf_fetch_client #(
    parameter int addr_width = 1,
    parameter int data_width = 1,
    parameter int name_width = 1,
    parameter int zero_reg   = 1,
    parameter int cnt_width  = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    bypass_rf_fetch_client_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_RESV, S_WAIT, S_FREE, S_DONE} state_t;

    state_t                state;

    logic [addr_width-1:0] rs1_p0;
    logic [addr_width-1:0] rs2_p0;
    logic [addr_width-1:0] rd_p0;
    logic                  need1_p0;
    logic                  need2_p0;
    logic                  needw_p0;

    logic [name_width-1:0] wname_p1;
    logic [name_width-1:0] rname1_p1;
    logic [name_width-1:0] rname2_p1;
    logic [data_width-1:0] opnd1_p1;
    logic [data_width-1:0] opnd2_p1;
    logic                  got1_p1;
    logic                  got2_p1;

    logic [data_width-1:0] resp_d1_p2;
    logic [data_width-1:0] resp_d2_p2;
    logic [name_width-1:0] resp_wname_p2;
    logic                  resp_has_wn_p2;
    logic [cnt_width-1:0]  stall_cnt;

    logic                  req_ready;
    logic                  accept;
    logic                  go;
    logic                  cap1;
    logic                  cap2;
    logic                  all_got;
    logic                  stall;
    logic                  req_need1;
    logic                  req_need2;
    logic                  req_needw;

    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
        return (&v) ? v : v + cnt_width'(1);
    endfunction

    assign req_need1 = !((zero_reg != 0) && (bus.REQ_RS1 == '0));
    assign req_need2 = !((zero_reg != 0) && (bus.REQ_RS2 == '0));
    assign req_needw = bus.REQ_HAS_RD && !((zero_reg != 0) && (bus.REQ_RD == '0));

    // Reset forces REQ_READY low even though the idle state would otherwise accept.
    assign req_ready = RST && ((state == S_IDLE) || ((state == S_DONE) && bus.RESP_READY));
    assign accept    = req_ready && bus.REQ_VALID;

    // All-or-nothing reservation: no enable fires unless every needed grant is available.
    assign go = (state == S_RESV)
             && (!needw_p0 || bus.ALLOC_READY)
             && (!need1_p0 || bus.RRES_READY_1)
             && (!need2_p0 || bus.RRES_READY_2);

    assign cap1    = (state == S_WAIT) && bus.VALID_OUT_1 && !got1_p1;
    assign cap2    = (state == S_WAIT) && bus.VALID_OUT_2 && !got2_p1;
    assign all_got = (got1_p1 || cap1) && (got2_p1 || cap2);
    assign stall   = ((state == S_RESV) && !go) || ((state == S_WAIT) && !all_got);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= S_IDLE;
            need1_p0       <= 1'b0;
            need2_p0       <= 1'b0;
            needw_p0       <= 1'b0;
            got1_p1        <= 1'b0;
            got2_p1        <= 1'b0;
            resp_d1_p2     <= '0;
            resp_d2_p2     <= '0;
            resp_wname_p2  <= '0;
            resp_has_wn_p2 <= 1'b0;
            stall_cnt      <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        need1_p0 <= req_need1;
                        need2_p0 <= req_need2;
                        needw_p0 <= req_needw;
                        state    <= S_RESV;
                    end else if (state == S_DONE && bus.RESP_READY) begin
                        state <= S_IDLE;
                    end
                end
                // p0 -> p1: request latched, reservations granted together
                S_RESV: begin
                    if (go) begin
                        got1_p1 <= !need1_p0;
                        got2_p1 <= !need2_p0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cap1) begin
                        got1_p1 <= 1'b1;
                    end
                    if (cap2) begin
                        got2_p1 <= 1'b1;
                    end
                    if (all_got) begin
                        state <= S_FREE;
                    end
                end
                // p1 -> p2: operands complete, response registered on entry to DONE
                S_FREE: begin
                    resp_d1_p2     <= opnd1_p1;
                    resp_d2_p2     <= opnd2_p1;
                    resp_wname_p2  <= needw_p0 ? wname_p1 : '0;
                    resp_has_wn_p2 <= needw_p0;
                    state          <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; control above qualifies every use.
    always_ff @(posedge CLK) begin
        if (accept) begin
            rs1_p0 <= bus.REQ_RS1;
            rs2_p0 <= bus.REQ_RS2;
            rd_p0  <= bus.REQ_RD;
        end
        if (go) begin
            wname_p1  <= bus.NAME_OUT;
            rname1_p1 <= need1_p0 ? bus.RNAME_OUT_1 : '0;
            rname2_p1 <= need2_p0 ? bus.RNAME_OUT_2 : '0;
            opnd1_p1  <= '0;
            opnd2_p1  <= '0;
        end
        if (cap1) begin
            opnd1_p1 <= bus.D_OUT_1;
        end
        if (cap2) begin
            opnd2_p1 <= bus.D_OUT_2;
        end
    end

    assign bus.REQ_READY    = req_ready;

    assign bus.ADDR_IN      = (state == S_RESV && needw_p0) ? rd_p0 : '0;
    assign bus.ALLOC_E      = go && needw_p0;
    assign bus.ADDR_1       = (state == S_RESV && need1_p0) ? rs1_p0 : '0;
    assign bus.ADDR_2       = (state == S_RESV && need2_p0) ? rs2_p0 : '0;
    assign bus.RRESE_1      = go && need1_p0;
    assign bus.RRESE_2      = go && need2_p0;

    assign bus.VALID_NAME_1 = (state == S_WAIT) ? rname1_p1 : '0;
    assign bus.VALID_NAME_2 = (state == S_WAIT) ? rname2_p1 : '0;
    assign bus.NAME_1       = (state == S_WAIT) ? rname1_p1 : '0;
    assign bus.NAME_2       = (state == S_WAIT) ? rname2_p1 : '0;

    assign bus.RD_F_1       = (state == S_FREE) ? rname1_p1 : '0;
    assign bus.RD_F_2       = (state == S_FREE) ? rname2_p1 : '0;
    assign bus.FE_1         = (state == S_FREE) && need1_p0;
    assign bus.FE_2         = (state == S_FREE) && need2_p0;

    assign bus.RESP_VALID   = (state == S_DONE);
    assign bus.RESP_D1      = resp_d1_p2;
    assign bus.RESP_D2      = resp_d2_p2;
    assign bus.RESP_WNAME   = resp_wname_p2;
    assign bus.RESP_HAS_WN  = resp_has_wn_p2;
    assign bus.STALL_CNT    = stall_cnt;
endmodule

// File: tb/tb_bypass_rf_fetch_client.sv
// Bench for bypass_rf_fetch_client: a timed register-file model drives the RF side per
// transaction, expected responses go through a scoreboard queue.
module tb_bypass_rf_fetch_client;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int NW = 4;
    localparam int CW = 16;

    typedef struct {
        int            rs1, rs2, rd;
        bit            has_rd;
        int            ad, r1d, r2d, v1d, v2d, hold;
        logic [DW-1:0] d1, d2;
        logic [NW-1:0] wn, rn1, rn2;
    } txn_t;

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [NW-1:0] wn;
        logic          has;
    } resp_t;

    logic  clk;
    logic  rst_n;
    int    checks = 0;
    int    errors = 0;
    resp_t sb[$];

    bypass_rf_fetch_client_if #(.addr_width(AW), .data_width(DW), .name_width(NW), .cnt_width(CW)) bus ();

    bypass_rf_fetch_client #(
        .addr_width(AW), .data_width(DW), .name_width(NW), .zero_reg(1), .cnt_width(CW)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic txn_t mk(input int rs1, input int rs2, input int rd, input bit has_rd,
                                input int ad, input int r1d, input int r2d, input int v1d,
                                input int v2d, input int hold, input logic [DW-1:0] d1,
                                input logic [DW-1:0] d2, input logic [NW-1:0] wn,
                                input logic [NW-1:0] rn1, input logic [NW-1:0] rn2);
        txn_t t;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.has_rd = has_rd;
        t.ad = ad; t.r1d = r1d; t.r2d = r2d; t.v1d = v1d; t.v2d = v2d; t.hold = hold;
        t.d1 = d1; t.d2 = d2; t.wn = wn; t.rn1 = rn1; t.rn2 = rn2;
        return t;
    endfunction

    task automatic drive_req(input txn_t t);
        bus.REQ_VALID  = 1'b1;
        bus.REQ_RS1    = AW'(t.rs1);
        bus.REQ_RS2    = AW'(t.rs2);
        bus.REQ_RD     = AW'(t.rd);
        bus.REQ_HAS_RD = t.has_rd;
    endtask

    // Register-file model: cycle c counts from the accept cycle (c = 0).
    task automatic drive_rf(input txn_t t, input int c, input int g, input int w);
        bus.ALLOC_READY  = (c >= 1 + t.ad);
        bus.RRES_READY_1 = (c >= 1 + t.r1d);
        bus.RRES_READY_2 = (c >= 1 + t.r2d);
        bus.NAME_OUT     = t.wn;
        bus.RNAME_OUT_1  = t.rn1;
        bus.RNAME_OUT_2  = t.rn2;
        bus.VALID_OUT_1  = (c >= g + 1 + t.v1d);
        bus.VALID_OUT_2  = (c >= g + 1 + t.v2d);
        bus.D_OUT_1      = (c == g + 1 + t.v1d) ? t.d1 : ~t.d1;
        bus.D_OUT_2      = (c == g + 1 + t.v2d) ? t.d2 : ~t.d2;
        bus.RESP_READY   = (c >= w + 2 + t.hold);
    endtask

    task automatic run_txn(input txn_t t, input bit pre_acc, input bit has_next, input txn_t nx);
        bit                 n1, n2, nw;
        int                 g, w, maxv, last, tries;
        int                 bad_res, bad_addr, bad_name, bad_free, bad_hs, bad_stable;
        logic [CW-1:0]      stall0;
        logic [2*DW+NW:0]   snap;
        resp_t              e;
        n1 = (t.rs1 != 0);
        n2 = (t.rs2 != 0);
        nw = t.has_rd && (t.rd != 0);
        g    = 1 + imax(nw ? t.ad : 0, imax(n1 ? t.r1d : 0, n2 ? t.r2d : 0));
        maxv = imax(n1 ? t.v1d : 0, n2 ? t.v2d : 0);
        w    = g + 1 + maxv;
        last = w + 2 + t.hold;
        bad_res = 0; bad_addr = 0; bad_name = 0; bad_free = 0; bad_hs = 0; bad_stable = 0;
        stall0 = '0;
        snap = '0;
        e.d1 = n1 ? t.d1 : '0;
        e.d2 = n2 ? t.d2 : '0;
        e.wn = nw ? t.wn : '0;
        e.has = nw;
        sb.push_back(e);
        if (!pre_acc) begin
            drive_req(t);
            drive_rf(t, 0, g, w);
            #1;
            tries = 0;
            while (!bus.REQ_READY && tries < 20) begin
                @(negedge clk);
                #1;
                tries++;
            end
            if (!bus.REQ_READY) begin
                chk("req_accept", 32'd0, 32'd1);
                void'(sb.pop_back());
                bus.REQ_VALID = 1'b0;
                return;
            end
            @(negedge clk);
        end
        for (int c = 1; c <= last; c++) begin
            bus.REQ_VALID = 1'b0;
            if (has_next && c == last) drive_req(nx);
            drive_rf(t, c, g, w);
            #1;
            if (c == 1) stall0 = bus.STALL_CNT;
            if (bus.ALLOC_E !== (nw && c == g)) bad_res++;
            if (bus.RRESE_1 !== (n1 && c == g)) bad_res++;
            if (bus.RRESE_2 !== (n2 && c == g)) bad_res++;
            if (bus.ADDR_IN !== ((nw && c <= g) ? AW'(t.rd) : '0)) bad_addr++;
            if (bus.ADDR_1 !== ((n1 && c <= g) ? AW'(t.rs1) : '0)) bad_addr++;
            if (bus.ADDR_2 !== ((n2 && c <= g) ? AW'(t.rs2) : '0)) bad_addr++;
            if (bus.VALID_NAME_1 !== ((c > g && c <= w && n1) ? t.rn1 : '0)) bad_name++;
            if (bus.VALID_NAME_2 !== ((c > g && c <= w && n2) ? t.rn2 : '0)) bad_name++;
            if (bus.NAME_1 !== bus.VALID_NAME_1 || bus.NAME_2 !== bus.VALID_NAME_2) bad_name++;
            if (bus.FE_1 !== (n1 && c == w + 1)) bad_free++;
            if (bus.FE_2 !== (n2 && c == w + 1)) bad_free++;
            if (bus.RD_F_1 !== ((c == w + 1 && n1) ? t.rn1 : '0)) bad_free++;
            if (bus.RD_F_2 !== ((c == w + 1 && n2) ? t.rn2 : '0)) bad_free++;
            if (bus.RESP_VALID !== (c >= w + 2)) bad_hs++;
            if (bus.REQ_READY !== (c == last)) bad_hs++;
            if (c == w + 2) snap = {bus.RESP_D1, bus.RESP_D2, bus.RESP_WNAME, bus.RESP_HAS_WN};
            if (c > w + 2 && {bus.RESP_D1, bus.RESP_D2, bus.RESP_WNAME, bus.RESP_HAS_WN} !== snap)
                bad_stable++;
            if (c == last) begin
                if (bus.RESP_VALID && bus.RESP_READY && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("resp_d1", 32'(bus.RESP_D1), 32'(e.d1));
                    chk("resp_d2", 32'(bus.RESP_D2), 32'(e.d2));
                    chk("resp_wname", 32'(bus.RESP_WNAME), 32'(e.wn));
                    chk("resp_has_wn", 32'(bus.RESP_HAS_WN), 32'(e.has));
                end else begin
                    chk("resp_handshake", 32'(bus.RESP_VALID), 32'd1);
                end
                chk("stall_cnt", 32'(CW'(bus.STALL_CNT - stall0)), 32'((g - 1) + maxv));
            end
            @(negedge clk);
        end
        chk("resv_enables", bad_res, 0);
        chk("resv_addr", bad_addr, 0);
        chk("slot_name", bad_name, 0);
        chk("free", bad_free, 0);
        chk("handshake", bad_hs, 0);
        chk("resp_stable", bad_stable, 0);
    endtask

    initial begin
        txn_t t1, t2, t3, t4, t5, t5b, t7;
        txn_t rt[8];
        bit   chain_prev, ch;

        rst_n = 1'b0;
        bus.REQ_VALID = 0; bus.REQ_RS1 = '0; bus.REQ_RS2 = '0; bus.REQ_RD = '0; bus.REQ_HAS_RD = 0;
        bus.ALLOC_READY = 0; bus.NAME_OUT = '0;
        bus.RRES_READY_1 = 0; bus.RRES_READY_2 = 0; bus.RNAME_OUT_1 = '0; bus.RNAME_OUT_2 = '0;
        bus.VALID_OUT_1 = 0; bus.VALID_OUT_2 = 0; bus.D_OUT_1 = '0; bus.D_OUT_2 = '0;
        bus.RESP_READY = 0;
        #12;
        bus.REQ_VALID = 1;
        #1;
        chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
        chk("rst_resp_valid", 32'(bus.RESP_VALID), 32'd0);
        chk("rst_stall_cnt", 32'(bus.STALL_CNT), 32'd0);
        chk("rst_resp_d1", 32'(bus.RESP_D1), 32'd0);
        chk("rst_resp_wname", 32'(bus.RESP_WNAME), 32'd0);
        bus.REQ_VALID = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        t1 = mk(3, 5, 7, 1, 0, 0, 0, 0, 0, 0, 16'h1111, 16'h2222, 4'h5, 4'h2, 4'h9);
        run_txn(t1, 0, 0, t1);
        t2 = mk(1, 2, 3, 1, 3, 0, 0, 0, 0, 0, 16'hA5A5, 16'h5A5A, 4'h7, 4'h1, 4'h3);
        run_txn(t2, 0, 0, t2);
        t3 = mk(6, 9, 10, 1, 0, 1, 0, 2, 0, 0, 16'hBEEF, 16'hCAFE, 4'hC, 4'h4, 4'hE);
        run_txn(t3, 0, 0, t3);
        t4 = mk(0, 4, 0, 1, 2, 1, 0, 0, 1, 0, 16'h0F0F, 16'h1234, 4'hB, 4'h6, 4'h8);
        run_txn(t4, 0, 0, t4);
        t5 = mk(11, 12, 13, 1, 0, 0, 0, 1, 1, 5, 16'h7777, 16'h8888, 4'h3, 4'hA, 4'hD);
        t5b = mk(14, 15, 16, 0, 0, 2, 0, 0, 0, 0, 16'h4321, 16'hFEDC, 4'h2, 4'h5, 4'hF);
        run_txn(t5, 0, 1, t5b);
        run_txn(t5b, 1, 0, t5b);

        // Reset asserted while the client waits for operand data.
        drive_req(mk(2, 3, 4, 1, 0, 0, 0, 0, 0, 0, '0, '0, 4'h1, 4'h3, 4'h4));
        bus.ALLOC_READY = 1; bus.RRES_READY_1 = 1; bus.RRES_READY_2 = 1;
        bus.NAME_OUT = 4'h1; bus.RNAME_OUT_1 = 4'h3; bus.RNAME_OUT_2 = 4'h4;
        bus.VALID_OUT_1 = 0; bus.VALID_OUT_2 = 0; bus.RESP_READY = 0;
        @(negedge clk);
        bus.REQ_VALID = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("wait_slot_name", 32'(bus.VALID_NAME_1), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(bus.REQ_READY), 32'd0);
        chk("mid_rst_valid_name", 32'(bus.VALID_NAME_1), 32'd0);
        chk("mid_rst_enables", 32'({bus.ALLOC_E, bus.RRESE_1, bus.RRESE_2, bus.FE_1, bus.FE_2}), 32'd0);
        chk("mid_rst_resp_valid", 32'(bus.RESP_VALID), 32'd0);
        chk("mid_rst_resp_d", 32'({bus.RESP_D1, bus.RESP_D2}), 32'd0);
        chk("mid_rst_has_wn", 32'({bus.RESP_WNAME, bus.RESP_HAS_WN}), 32'd0);
        chk("mid_rst_stall_cnt", 32'(bus.STALL_CNT), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        t7 = mk(8, 0, 9, 1, 1, 0, 0, 0, 0, 1, 16'h600D, 16'hBAD0, 4'h9, 4'h7, 4'h1);
        run_txn(t7, 0, 0, t7);

        for (int i = 0; i < 8; i++) begin
            rt[i] = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 2), DW'($urandom), DW'($urandom),
                       NW'($urandom), NW'($urandom), NW'($urandom));
        end
        chain_prev = 0;
        for (int i = 0; i < 8; i++) begin
            ch = (i < 7) && ($urandom_range(0, 1) == 1);
            run_txn(rt[i], chain_prev, ch, ch ? rt[i + 1] : rt[i]);
            chain_prev = ch;
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
